// File: rtl/pc_unit_if.sv
// Purpose : control/status bundle between the control unit and the program-counter unit.
// Ports   : master drives stall/branch/jump/call/ret and targets, observes pc/pc_plus/RAS status;
//           slave (pc_unit) receives the controls and drives the status.
interface pc_unit_if #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned RAS_DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

   logic             stall;
   logic             branch_taken;
   logic [WIDTH-1:0] branch_target;
   logic             jump;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] jump_target;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus;
   logic [CNT_W-1:0] ras_count;
   logic             ras_overflow;
   logic             ras_underflow;

   modport master (
      output stall, branch_taken, branch_target, jump, call, ret, jump_target,
      input  pc, pc_plus, ras_count, ras_overflow, ras_underflow
   );

   modport slave (
      input  stall, branch_taken, branch_target, jump, call, ret, jump_target,
      output pc, pc_plus, ras_count, ras_overflow, ras_underflow
   );
endinterface

// File: rtl/pc_unit.sv
// Purpose : program counter with fixed-priority next-pc selection, stall and a
//           circular return-address stack for call/ret.
// Ports   : clk, reset (synchronous, active-high);
//           bus (pc_unit_if.slave): stall, branch_taken/branch_target, jump, call, ret,
//           jump_target in; pc (registered), pc_plus (pc + STEP, combinational),
//           ras_count, sticky ras_overflow / ras_underflow out.
module pc_unit #(
   parameter int unsigned      WIDTH        = 32,
   parameter int unsigned      STEP         = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned      RAS_DEPTH    = 4
) (
   input logic      clk,
   input logic      reset,
   pc_unit_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] pc_q, pc_d, pc_plus;
   logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             push;
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

   assign pc_plus = pc_q + WIDTH'(STEP);
   // Pointer addresses the next free slot; the newest entry sits just below it.
   assign top_idx = ptr_q - PTR_W'(1);

   // Next-state selection: ret > call > jump > branch > sequential, all frozen by stall.
   always_comb begin
      pc_d  = pc_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      push  = 1'b0;
      if (!bus.stall) begin
         if (bus.ret) begin
            if (cnt_q != '0) begin
               pc_d  = ras_mem[top_idx];
               ptr_d = top_idx;
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               pc_d  = pc_plus;
               unf_d = 1'b1;
            end
         end else if (bus.call) begin
            push  = 1'b1;
            pc_d  = bus.jump_target;
            // Power-of-two depth: pointer wraps onto the oldest entry when full.
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q == CNT_W'(RAS_DEPTH)) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else if (bus.jump) begin
            pc_d = bus.jump_target;
         end else if (bus.branch_taken) begin
            pc_d = bus.branch_target;
         end else begin
            pc_d = pc_plus;
         end
      end
   end

   // State register; reset overrides stall and any pending push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_VECTOR;
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // RAS storage; contents are not cleared by reset, only the pointer/count are.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         ras_mem[ptr_q] <= pc_plus;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.pc_plus       = pc_plus;
   assign bus.ras_count     = cnt_q;
   assign bus.ras_overflow  = ovf_q;
   assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Purpose : self-checking bench for pc_unit: directed scenarios plus randomized
//           control traffic compared against a queue-based reference model.
module tb_pc_unit;
   localparam int unsigned W     = 32;
   localparam int unsigned STEP  = 4;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clk = ~clk;

   pc_unit_if #(.WIDTH(W), .RAS_DEPTH(DEPTH)) bus ();
   pc_unit_if #(.WIDTH(8), .RAS_DEPTH(DEPTH)) bus8 ();

   pc_unit #(.WIDTH(W), .STEP(STEP), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave));

   pc_unit #(.WIDTH(8), .STEP(4), .RESET_VECTOR(8'hF4), .RAS_DEPTH(DEPTH)) dut8 (
      .clk(clk), .reset(reset), .bus(bus8.slave));

   // Reference model: pc value, return addresses as a bounded queue (oldest at front).
   logic [W-1:0] m_pc;
   logic [W-1:0] m_q[$];
   logic         m_ovf, m_unf;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      if (reset) begin
         m_pc = '0;
         m_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (bus.stall) begin
         m_pc = m_pc;
      end else if (bus.ret) begin
         if (m_q.size() > 0) m_pc = m_q.pop_back();
         else begin
            m_pc  = W'(m_pc + STEP);
            m_unf = 1'b1;
         end
      end else if (bus.call) begin
         if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            m_ovf = 1'b1;
         end
         m_q.push_back(W'(m_pc + STEP));
         m_pc = bus.jump_target;
      end else if (bus.jump) begin
         m_pc = bus.jump_target;
      end else if (bus.branch_taken) begin
         m_pc = bus.branch_target;
      end else begin
         m_pc = W'(m_pc + STEP);
      end
   endtask

   // One clock: update model at the edge, compare all outputs 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      chk("pc",         64'(bus.pc),            64'(m_pc));
      chk("pc_plus",    64'(bus.pc_plus),       64'(W'(m_pc + STEP)));
      chk("ras_count",  64'(bus.ras_count),     64'(m_q.size()));
      chk("overflow",   64'(bus.ras_overflow),  64'(m_ovf));
      chk("underflow",  64'(bus.ras_underflow), 64'(m_unf));
   endtask

   task automatic idle();
      reset = 1'b0;
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
      bus.call = 1'b0;  bus.ret = 1'b0;
   endtask

   task automatic do_call(input logic [W-1:0] tgt);
      idle(); bus.call = 1'b1; bus.jump_target = tgt; step();
   endtask

   task automatic do_ret();
      idle(); bus.ret = 1'b1; step();
   endtask

   task automatic do_jump(input logic [W-1:0] tgt);
      idle(); bus.jump = 1'b1; bus.jump_target = tgt; step();
   endtask

   initial begin
      m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;
      bus.branch_target = '0; bus.jump_target = '0;
      bus8.stall = 1'b0; bus8.branch_taken = 1'b0; bus8.branch_target = '0;
      bus8.jump = 1'b0; bus8.call = 1'b0; bus8.ret = 1'b0; bus8.jump_target = '0;
      idle();

      // Reset and sequential stepping (8-bit instance wraps F4 -> F8 -> FC -> 00).
      reset = 1'b1; step();
      chk("rst_pc", 64'(bus.pc), 64'h0);
      chk("rst_pc_plus", 64'(bus.pc_plus), 64'h4);
      chk("rst8_pc", 64'(bus8.pc), 64'hF4);
      idle(); step();
      chk("seq_pc1", 64'(bus.pc), 64'h4);
      chk("w8_pc1", 64'(bus8.pc), 64'hF8);
      step();
      chk("seq_pc2", 64'(bus.pc), 64'h8);
      chk("w8_pc2", 64'(bus8.pc), 64'hFC);
      step();
      chk("seq_pc3", 64'(bus.pc), 64'hC);
      chk("w8_wrap", 64'(bus8.pc), 64'h00);
      chk("w8_wrap_plus", 64'(bus8.pc_plus), 64'h04);

      // Branch, stall blocking a jump, then jump.
      idle(); bus.branch_taken = 1'b1; bus.branch_target = 32'h40; step();
      chk("branch", 64'(bus.pc), 64'h40);
      idle(); bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h999; step();
      chk("stall_hold", 64'(bus.pc), 64'h40);
      do_jump(32'h100);
      chk("jump", 64'(bus.pc), 64'h100);

      // Nested call/return.
      do_jump(32'h10);
      do_call(32'h200); chk("call1_cnt", 64'(bus.ras_count), 64'd1);
      do_call(32'h300); chk("call2_pc", 64'(bus.pc), 64'h300);
      do_ret();         chk("ret1_pc", 64'(bus.pc), 64'h204);
      do_ret();         chk("ret2_pc", 64'(bus.pc), 64'h14);
      chk("ret2_cnt", 64'(bus.ras_count), 64'd0);

      // Overflow: five calls from 0x1000..0x5000, then five rets.
      do_jump(32'h1000);
      for (int i = 2; i <= 6; i++) do_call(W'(i) << 12);
      chk("ovf_cnt", 64'(bus.ras_count), 64'd4);
      chk("ovf_flag", 64'(bus.ras_overflow), 64'd1);
      for (int i = 5; i >= 2; i--) begin
         do_ret();
         chk("ovf_ret_pc", 64'(bus.pc), 64'((W'(i) << 12) + 4));
      end
      do_ret();
      chk("unf_pc", 64'(bus.pc), 64'h2008);
      chk("unf_flag", 64'(bus.ras_underflow), 64'd1);
      chk("unf_cnt", 64'(bus.ras_count), 64'd0);

      // Simultaneous call and ret: ret wins.
      idle(); reset = 1'b1; step();
      do_jump(32'h7C);
      do_call(32'h500);
      idle(); bus.call = 1'b1; bus.ret = 1'b1; bus.jump_target = 32'h900; step();
      chk("prio_pc", 64'(bus.pc), 64'h80);
      chk("prio_cnt", 64'(bus.ras_count), 64'd0);

      // Reset in the middle of a call/ret sequence.
      do_call(32'hA00);
      do_call(32'hB00);
      idle(); reset = 1'b1; bus.ret = 1'b1; bus.stall = 1'b1; step();
      chk("midrst_pc", 64'(bus.pc), 64'h0);
      chk("midrst_cnt", 64'(bus.ras_count), 64'd0);

      // Randomized control traffic against the model.
      for (int n = 0; n < 400; n++) begin
         reset             = ($urandom_range(0, 49) == 0);
         bus.stall         = ($urandom_range(0, 5) == 0);
         bus.ret           = ($urandom_range(0, 3) == 0);
         bus.call          = ($urandom_range(0, 3) == 0);
         bus.jump          = ($urandom_range(0, 5) == 0);
         bus.branch_taken  = ($urandom_range(0, 2) == 0);
         bus.jump_target   = W'($urandom) & 32'hFFFF_FFFC;
         bus.branch_target = W'($urandom) & 32'hFFFF_FFFC;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
